// File: rtl/pixel_scan_ctrl.sv
// Frame scanner: per pixel one memory read (FETCH), then present L/A/B with coordinates (PUSH).
// Best case 2 cycles per pixel; a late rd_ack or a low out_ready holds the current state and outputs.
module pixel_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 20
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              abort,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [31:0]       rd_L,
  input  logic [31:0]       rd_A,
  input  logic [31:0]       rd_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_L,
  output logic [31:0]       out_A,
  output logic [31:0]       out_B,
  output logic [11:0]       Pixel_Col_cnt,
  output logic [11:0]       Pixel_Row_cnt,
  output logic              pixel_tick,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] a;
    logic [31:0] b;
  } lab_t;

  localparam logic [11:0] COL_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] ROW_LAST = 12'(V_ACTIVE - 1);

  state_t      state, state_nxt;
  lab_t        pix_q;
  logic [11:0] col_q, row_q;
  logic [ADDR_W-1:0] addr_q;
  logic        rd_fire, out_fire, clr_cnt, adv_cnt, enter_fetch, last_pix;

  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_ff @(posedge clk50) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort overrides every handshake, so a simultaneous rd_ack or out_ready has no effect
  always_comb begin
    state_nxt   = state;
    rd_req      = 1'b0;
    out_valid   = 1'b0;
    frame_done  = 1'b0;
    busy        = (state != IDLE);
    rd_fire     = 1'b0;
    out_fire    = 1'b0;
    clr_cnt     = 1'b0;
    adv_cnt     = 1'b0;
    enter_fetch = 1'b0;
    case (state)
      IDLE: begin
        clr_cnt = 1'b1;
        if (start && !abort) begin
          state_nxt   = FETCH;
          enter_fetch = 1'b1;
        end
      end
      FETCH: begin
        rd_req = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (rd_ack) begin
          rd_fire   = 1'b1;
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        out_valid = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          out_fire = 1'b1;
          if (last_pix) begin
            state_nxt = DONE;
          end else begin
            adv_cnt   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        frame_done = !abort;
        clr_cnt    = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (cont_mode) begin
          state_nxt   = FETCH;
          enter_fetch = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      pix_q       <= '0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= out_fire;
      frame_start <= enter_fetch;
      if (rd_fire) begin
        pix_q <= '{l: rd_L, a: rd_A, b: rd_B};
      end
      // linear address tracks the raster walk incrementally instead of row*H_ACTIVE+col
      if (clr_cnt) begin
        col_q  <= '0;
        row_q  <= '0;
        addr_q <= '0;
      end else if (adv_cnt) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 12'd1;
        end else begin
          col_q <= col_q + 12'd1;
        end
      end
    end
  end

  assign rd_addr       = addr_q;
  assign out_L         = pix_q.l;
  assign out_A         = pix_q.a;
  assign out_B         = pix_q.b;
  assign Pixel_Col_cnt = col_q;
  assign Pixel_Row_cnt = row_q;

endmodule
